cfi_check_sched: RTL and testbench

Drains the CFI commit-log queue and sequences each entry through the external CFI checker, one check in flight at a time. It sits between the CFI log queue (fed by the commit-side queue controller) and the checker's request/response port. It raises a sticky fault on a checker-reported violation or a response timeout. It also keeps a saturating count of completed checks for debug and performance visibility.

---
 rtl/cfi_pkg.sv | 16 +
 rtl/cfi_check_sched.sv | 105 ++++++++++
 tb/tb_cfi_check_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfi_pkg.sv
// Types shared between the CFI commit-log queue controller and the check scheduler.
package cfi_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  kind;
    } cfi_commit_log_t;

    typedef enum logic [1:0] {
        CFI_FAULT_NONE      = 2'd0,
        CFI_FAULT_VIOLATION = 2'd1,
        CFI_FAULT_TIMEOUT   = 2'd2
    } cfi_fault_cause_t;

endpackage

// File: rtl/cfi_check_sched.sv
// Pops CFI commit-log entries and runs them through the external checker one at a time,
// latching a sticky fault on a violation or a response timeout.
module cfi_check_sched
    import cfi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 queue_empty_i,
    input  cfi_commit_log_t      queue_data_i,
    output logic                 queue_pop_o,
    output logic                 chk_req_valid_o,
    input  logic                 chk_req_ready_i,
    output cfi_commit_log_t      chk_req_data_o,
    input  logic                 chk_rsp_valid_i,
    input  logic                 chk_rsp_ok_i,
    output logic                 cfi_busy_o,
    output logic                 cfi_fault_o,
    output cfi_fault_cause_t     cfi_fault_cause_o,
    output logic [CNT_WIDTH-1:0] chk_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FAULT} state_e;

    state_e               state_q, state_d;
    cfi_commit_log_t      req_q, req_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    cfi_fault_cause_t     cause_q, cause_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop;

    assign pop = (state_q == S_IDLE) && enable_i && !queue_empty_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            tmo_q   <= '0;
            cause_q <= CFI_FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tmo_d   = tmo_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    req_d   = queue_data_i;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (chk_req_ready_i) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the last timeout cycle still wins over the timeout.
                if (chk_rsp_valid_i) begin
                    if (chk_rsp_ok_i) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                        state_d = S_IDLE;
                    end else begin
                        cause_d = CFI_FAULT_VIOLATION;
                        state_d = S_FAULT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cause_d = CFI_FAULT_TIMEOUT;
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    assign queue_pop_o       = pop;
    assign chk_req_valid_o   = (state_q == S_SEND);
    assign chk_req_data_o    = req_q;
    assign cfi_busy_o        = (state_q != S_IDLE);
    assign cfi_fault_o       = (state_q == S_FAULT);
    assign cfi_fault_cause_o = cause_q;
    assign chk_cnt_o         = cnt_q;

endmodule

// File: tb/tb_cfi_check_sched.sv
// Directed bench for cfi_check_sched: a per-cycle vector table plus multi-cycle sequences.
module tb_cfi_check_sched;
    import cfi_pkg::*;

    localparam int TMO = 8;
    localparam int CW  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en, rdy, rv, ok;
    logic             queue_empty, pop, valid, busy, fault;
    cfi_commit_log_t  queue_data, req_data;
    cfi_fault_cause_t cause;
    logic [CW-1:0]    cnt;

    always #5 clk = ~clk;

    cfi_check_sched #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .queue_empty_i(queue_empty), .queue_data_i(queue_data), .queue_pop_o(pop),
        .chk_req_valid_o(valid), .chk_req_ready_i(rdy), .chk_req_data_o(req_data),
        .chk_rsp_valid_i(rv), .chk_rsp_ok_i(ok),
        .cfi_busy_o(busy), .cfi_fault_o(fault), .cfi_fault_cause_o(cause), .chk_cnt_o(cnt)
    );

    function automatic cfi_commit_log_t mk(input int i);
        cfi_commit_log_t e;
        e.pc     = 32'h1000 + 32'(i) * 4;
        e.target = 32'h8000_0000 ^ (32'(i) << 4);
        e.kind   = 2'(i);
        return e;
    endfunction

    // FWFT queue model; the table mode overrides emptiness directly.
    cfi_commit_log_t qmem [32];
    int   qhead, qtail;
    logic use_tbl, tbl_empty;
    assign queue_empty = use_tbl ? tbl_empty : (qhead == qtail);
    assign queue_data  = use_tbl ? mk(7) : qmem[qhead & 31];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) qhead <= 0;
        else if (pop && !queue_empty) qhead <= qhead + 1;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        en = 0; rdy = 0; rv = 0; ok = 0; use_tbl = 0; tbl_empty = 1; qtail = 0;
        rst_n = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            qmem[qtail & 31] = mk(base + i);
            qtail++;
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        #1;
        while (!valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (!valid) begin
            bad++;
            $display("FAIL %s: no request within 20 cycles, valid=%0b expected 1", nm, valid);
        end
    endtask

    // Call while a request is visible with rdy high: answer on the first WAIT cycle.
    task automatic finish(input logic rsp_ok);
        @(negedge clk); rv = 1; ok = rsp_ok;
        @(negedge clk); rv = 0; ok = 0;
        #1;
    endtask

    typedef struct {
        logic en, emp, rdy, rv, ok;
        logic e_pop, e_vld, e_busy, e_flt;
        logic [1:0] e_cause;
        logic [CW-1:0] e_cnt;
    } vec_t;
    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1,0,0,0,0, 1,0,0,0, 0,0};
        tbl[1]  = '{1,0,0,0,0, 0,1,1,0, 0,0};
        tbl[2]  = '{1,0,1,0,0, 0,1,1,0, 0,0};
        tbl[3]  = '{1,0,0,1,1, 0,0,1,0, 0,0};
        tbl[4]  = '{0,0,0,0,0, 0,0,0,0, 0,1};
        tbl[5]  = '{1,1,0,0,0, 0,0,0,0, 0,1};
        tbl[6]  = '{1,0,0,0,0, 1,0,0,0, 0,1};
        tbl[7]  = '{0,0,0,1,0, 0,1,1,0, 0,1};
        tbl[8]  = '{0,0,1,0,0, 0,1,1,0, 0,1};
        tbl[9]  = '{0,0,0,0,0, 0,0,1,0, 0,1};
        tbl[10] = '{0,0,0,1,1, 0,0,1,0, 0,1};
        tbl[11] = '{0,0,0,0,0, 0,0,0,0, 0,2};
        tbl[12] = '{0,0,0,1,1, 0,0,0,0, 0,2};
        tbl[13] = '{0,0,0,1,0, 0,0,0,0, 0,2};
        tbl[14] = '{0,0,0,0,0, 0,0,0,0, 0,2};

        // Reset state
        do_reset();
        #1;
        chk("rst_pop", pop, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cause", cause, CFI_FAULT_NONE);
        chk("rst_cnt", cnt, 0);
        chk("rst_data", req_data, 0);

        // Per-cycle vectors
        use_tbl = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            en = tbl[i].en; tbl_empty = tbl[i].emp; rdy = tbl[i].rdy;
            rv = tbl[i].rv; ok = tbl[i].ok;
            #1;
            chk($sformatf("tbl%0d_pop", i), pop, tbl[i].e_pop);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_vld);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_fault", i), fault, tbl[i].e_flt);
            chk($sformatf("tbl%0d_cause", i), cause, tbl[i].e_cause);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_data", i), req_data, mk(7));
        end

        // Three entries in FIFO order, ready high, OK one cycle after accept
        do_reset();
        load(3, 0); en = 1; rdy = 1;
        for (int i = 0; i < 3; i++) begin
            wait_valid("fifo_valid");
            chk($sformatf("fifo_data%0d", i), req_data, mk(i));
            finish(1);
        end
        chk("fifo_cnt", cnt, 3);
        chk("fifo_fault", fault, 0);
        chk("fifo_pops", qhead, 3);
        chk("fifo_idle", busy, 0);

        // Backpressure: ready low for 5 cycles in SEND
        do_reset();
        load(2, 10); en = 1; rdy = 0;
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_valid%0d", i), valid, 1);
            chk($sformatf("bp_data%0d", i), req_data, mk(10));
            chk($sformatf("bp_pops%0d", i), qhead, 1);
        end
        rdy = 1;
        finish(1);
        chk("bp_cnt", cnt, 1);

        // Violation on entry 2 of 4
        do_reset();
        load(4, 20); en = 1; rdy = 1;
        wait_valid("viol_v0");
        finish(1);
        wait_valid("viol_v1");
        chk("viol_data1", req_data, mk(21));
        finish(0);
        chk("viol_fault", fault, 1);
        chk("viol_cause", cause, CFI_FAULT_VIOLATION);
        chk("viol_cnt", cnt, 1);
        rv = 1; ok = 1;
        repeat (4) @(negedge clk);
        rv = 0; #1;
        chk("viol_pops", qhead, 2);
        chk("viol_valid", valid, 0);
        chk("viol_cnt_hold", cnt, 1);
        chk("viol_sticky", fault, 1);

        // Timeout: no response for TMO WAIT cycles
        do_reset();
        load(1, 30); en = 1; rdy = 1;
        wait_valid("tmo_valid");
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk); #1;
            chk($sformatf("tmo_wait%0d", i), {busy, fault}, 2'b10);
        end
        @(negedge clk); #1;
        chk("tmo_fault", fault, 1);
        chk("tmo_cause", cause, CFI_FAULT_TIMEOUT);

        // OK response on the final WAIT cycle beats the timeout
        do_reset();
        load(1, 40); en = 1; rdy = 1;
        wait_valid("tmo_edge_valid");
        repeat (TMO - 1) @(negedge clk);
        @(negedge clk); rv = 1; ok = 1;
        @(negedge clk); rv = 0; ok = 0; #1;
        chk("tmo_edge_fault", fault, 0);
        chk("tmo_edge_cause", cause, CFI_FAULT_NONE);
        chk("tmo_edge_cnt", cnt, 1);
        chk("tmo_edge_idle", busy, 0);

        // enable dropped during WAIT
        do_reset();
        load(2, 50); en = 1; rdy = 1;
        wait_valid("en_valid");
        @(negedge clk); en = 0;
        @(negedge clk); rv = 1; ok = 1;
        @(negedge clk); rv = 0; ok = 0; #1;
        chk("en_cnt", cnt, 1);
        chk("en_idle", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("en_nopop", pop, 0);
        chk("en_pops", qhead, 1);
        en = 1; #1;
        chk("en_resume_pop", pop, 1);

        // Async reset in WAIT, then spurious responses in IDLE
        do_reset();
        load(2, 60); en = 1; rdy = 1;
        wait_valid("ar_v0");
        finish(1);
        wait_valid("ar_v1");
        @(negedge clk); en = 0; #1;
        chk("ar_in_wait", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", valid, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_data", req_data, 0);
        chk("ar_fault", fault, 0);
        @(negedge clk); rst_n = 1;
        rv = 1; ok = 1;
        @(negedge clk); ok = 0;
        @(negedge clk); rv = 0; #1;
        chk("spur_cnt", cnt, 0);
        chk("spur_busy", busy, 0);
        chk("spur_fault", fault, 0);
        chk("spur_cause", cause, CFI_FAULT_NONE);

        // Counter saturation
        do_reset();
        load(17, 70); en = 1; rdy = 1;
        for (int i = 0; i < 17; i++) begin
            wait_valid("sat_valid");
            finish(1);
        end
        chk("sat_cnt", cnt, 4'hF);
        chk("sat_fault", fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
